// File: rtl/inhibitor_pkg.sv
// Shared constants and helpers for the inhibitor bank.
package inhibitor_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // Counters up to 64 bits wide; callers zero-extend and truncate around this.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
        if (value >= max)
            sat_inc = max;
        else
            sat_inc = value + 64'd1;
    endfunction

endpackage

// File: rtl/inhibitor_lane.sv
// One-bit inhibit gate: passes data when enabled (active-low) and flags blocked data.
module inhibitor_lane (
    input  logic i_in,
    input  logic i_en_l,
    input  logic i_force,
    output logic o_out,
    output logic o_blocked
);

    // i_force acts like a second inhibit, so it both kills the output and marks the lane blocked.
    assign o_out     = i_in & ~i_en_l & ~i_force;
    assign o_blocked = i_in & (i_en_l | i_force);

endmodule

// File: rtl/inhibitor_bank.sv
// WIDTH-lane inhibit gate with registered output, sticky blocked flags and a saturating counter.
// Optional global_inhibit input enabled by defining INHIBITOR_GLOBAL_EN.
module inhibitor_bank
    import inhibitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] enable_l,
`ifdef INHIBITOR_GLOBAL_EN
    input  logic             global_inhibit,
`endif
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] blocked_sticky,
    output logic [CNT_W-1:0] blocked_cnt
);

    logic             w_force;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_blocked;
    logic             w_any;
    logic [63:0]      w_cnt_max;
    logic [CNT_W-1:0] w_cnt_next;

    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_cnt;

`ifdef INHIBITOR_GLOBAL_EN
    assign w_force = global_inhibit;
`else
    assign w_force = 1'b0;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        inhibitor_lane u_lane (
            .i_in      (in[g]),
            .i_en_l    (enable_l[g]),
            .i_force   (w_force),
            .o_out     (w_out[g]),
            .o_blocked (w_blocked[g])
        );
    end

    assign w_any      = |w_blocked;
    assign w_cnt_max  = 64'({CNT_W{1'b1}});
    assign w_cnt_next = CNT_W'(sat_inc(64'(r_cnt), w_cnt_max));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_q  <= '0;
            r_sticky <= '0;
            r_cnt    <= '0;
        end else begin
            r_out_q <= w_out;
            // clear outranks a same-cycle blocked event
            if (clear) begin
                r_sticky <= '0;
                r_cnt    <= '0;
            end else begin
                r_sticky <= r_sticky | w_blocked;
                if (w_any)
                    r_cnt <= w_cnt_next;
            end
        end
    end

    assign out            = w_out;
    assign out_q          = r_out_q;
    assign blocked_sticky = r_sticky;
    assign blocked_cnt    = r_cnt;

endmodule

// File: tb/tb_inhibitor_bank.sv
// Self-checking bench: a 1-lane default-width instance and a 4-lane instance with a 2-bit counter.
module tb_inhibitor_bank;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        glob = 1'b0;
    logic        in1 = 1'b0, en1 = 1'b0;
    logic [3:0]  in4 = '0, en4 = '0;
    logic        out1, outq1, sticky1;
    logic [15:0] cnt1;
    logic [3:0]  out4, outq4, sticky4;
    logic [1:0]  cnt4;

    int errors = 0;
    int checks = 0;

    // reference state
    logic       m_outq1, m_sticky1;
    logic [3:0] m_outq4, m_sticky4;
    int         m_cnt1, m_cnt4;

    inhibitor_bank dut1 (
        .clk(clk), .reset(reset), .in(in1), .enable_l(en1),
`ifdef INHIBITOR_GLOBAL_EN
        .global_inhibit(glob),
`endif
        .clear(clear), .out(out1), .out_q(outq1),
        .blocked_sticky(sticky1), .blocked_cnt(cnt1)
    );

    inhibitor_bank #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .reset(reset), .in(in4), .enable_l(en4),
`ifdef INHIBITOR_GLOBAL_EN
        .global_inhibit(glob),
`endif
        .clear(clear), .out(out4), .out_q(outq4),
        .blocked_sticky(sticky4), .blocked_cnt(cnt4)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Advance one rising edge, updating the reference from the inputs seen at that edge.
    task automatic tick();
        logic [3:0] b4, g4;
        logic       b1;
        g4 = {4{glob}};
        b4 = in4 & (en4 | g4);
        b1 = in1 & (en1 | glob);
        @(posedge clk);
        if (reset) begin
            m_outq1 = 0; m_sticky1 = 0; m_cnt1 = 0;
            m_outq4 = 0; m_sticky4 = 0; m_cnt4 = 0;
        end else begin
            m_outq1 = in1 & ~en1 & ~glob;
            m_outq4 = in4 & ~en4 & ~g4;
            if (clear) begin
                m_sticky1 = 0; m_cnt1 = 0;
                m_sticky4 = 0; m_cnt4 = 0;
            end else begin
                m_sticky1 = m_sticky1 | b1;
                m_sticky4 = m_sticky4 | b4;
                if (b1) m_cnt1 = (m_cnt1 + 1 > 65535) ? 65535 : m_cnt1 + 1;
                if (b4 != 0) m_cnt4 = (m_cnt4 + 1 > 3) ? 3 : m_cnt4 + 1;
            end
        end
        #1;
    endtask

    task automatic test_comb_noclk();
        in1 = 1; en1 = 1; #10;
        checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL comb_11 out=%b exp=0", out1); end
        en1 = 0; #10;
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL comb_10 out=%b exp=1", out1); end
        in1 = 0; #10;
        checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL comb_00 out=%b exp=0", out1); end
        en1 = 1; #10;
        checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL comb_01 out=%b exp=0", out1); end
    endtask

    task automatic test_reset();
        clk_run = 1; #2;
        reset = 1; in1 = 1; en1 = 0; in4 = 4'hF; en4 = 4'hF;
        tick(); tick();
        checks++; if ({outq1, sticky1, cnt1} !== 18'd0) begin errors++; $display("FAIL reset_w1 got=%h exp=0", {outq1, sticky1, cnt1}); end
        checks++; if ({outq4, sticky4, cnt4} !== 10'd0) begin errors++; $display("FAIL reset_w4 got=%h exp=0", {outq4, sticky4, cnt4}); end
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL reset_out_comb out=%b exp=1", out1); end
        reset = 0; in4 = 0; en4 = 0;
    endtask

    task automatic test_out_q();
        in1 = 1; en1 = 0; #1;
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL outq_pre_out out=%b exp=1", out1); end
        tick();
        checks++; if (outq1 !== 1'b1) begin errors++; $display("FAIL outq_follow out_q=%b exp=1", outq1); end
        reset = 1; tick(); reset = 0;
        checks++; if (outq1 !== 1'b0) begin errors++; $display("FAIL outq_reset out_q=%b exp=0", outq1); end
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL outq_reset_out out=%b exp=1", out1); end
        tick();
        checks++; if (outq1 !== 1'b1) begin errors++; $display("FAIL outq_resume out_q=%b exp=1", outq1); end
    endtask

    task automatic test_width4();
        in1 = 0; in4 = 0; clear = 1; tick(); clear = 0;
        in4 = 4'b1111; en4 = 4'b1010; #1;
        checks++; if (out4 !== 4'b0101) begin errors++; $display("FAIL w4_out out=%b exp=0101", out4); end
        tick();
        checks++; if (sticky4 !== 4'b1010) begin errors++; $display("FAIL w4_sticky got=%b exp=1010", sticky4); end
        checks++; if (cnt4 !== 2'd1) begin errors++; $display("FAIL w4_cnt got=%0d exp=1", cnt4); end
        checks++; if (outq4 !== 4'b0101) begin errors++; $display("FAIL w4_outq got=%b exp=0101", outq4); end
    endtask

    task automatic test_saturate();
        int exp_seq[6] = '{1, 2, 3, 3, 3, 3};
        in4 = 0; clear = 1; tick(); clear = 0;
        in4 = 4'b0001; en4 = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (cnt4 !== 2'(exp_seq[i])) begin errors++; $display("FAIL sat_cyc%0d got=%0d exp=%0d", i, cnt4, exp_seq[i]); end
        end
        clear = 1; tick(); clear = 0;
        checks++; if (cnt4 !== 2'd0) begin errors++; $display("FAIL clear_wins_cnt got=%0d exp=0", cnt4); end
        checks++; if (sticky4 !== 4'b0) begin errors++; $display("FAIL clear_wins_sticky got=%b exp=0", sticky4); end
        in4 = 0; en4 = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            in1 = 1'($urandom); en1 = 1'($urandom);
            in4 = 4'($urandom); en4 = 4'($urandom);
            clear = ($urandom_range(0, 9) == 0);
            #1;
            checks++; if (out4 !== (in4 & ~en4)) begin errors++; $display("FAIL rnd_out4 i=%0d got=%b exp=%b", i, out4, in4 & ~en4); end
            tick();
            checks++; if (outq4 !== m_outq4 || sticky4 !== m_sticky4 || cnt4 !== 2'(m_cnt4)) begin
                errors++; $display("FAIL rnd_w4 i=%0d got q=%b s=%b c=%0d exp q=%b s=%b c=%0d", i, outq4, sticky4, cnt4, m_outq4, m_sticky4, m_cnt4);
            end
            checks++; if (outq1 !== m_outq1 || sticky1 !== m_sticky1 || cnt1 !== 16'(m_cnt1)) begin
                errors++; $display("FAIL rnd_w1 i=%0d got q=%b s=%b c=%0d exp q=%b s=%b c=%0d", i, outq1, sticky1, cnt1, m_outq1, m_sticky1, m_cnt1);
            end
        end
        clear = 0;
    endtask

`ifdef INHIBITOR_GLOBAL_EN
    task automatic test_global();
        int c0;
        in1 = 1; en1 = 0; glob = 1; #1;
        c0 = m_cnt1;
        checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL glob_out out=%b exp=0", out1); end
        tick();
        checks++; if (cnt1 !== 16'(c0 + 1)) begin errors++; $display("FAIL glob_cnt got=%0d exp=%0d", cnt1, c0 + 1); end
        checks++; if (outq1 !== 1'b0 || sticky1 !== 1'b1) begin errors++; $display("FAIL glob_regs q=%b s=%b exp q=0 s=1", outq1, sticky1); end
        glob = 0; #1;
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL glob_drop out=%b exp=1", out1); end
    endtask
`endif

    initial begin
        test_comb_noclk();
        test_reset();
        test_out_q();
        test_width4();
        test_saturate();
        test_random();
`ifdef INHIBITOR_GLOBAL_EN
        test_global();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
